// File: rtl/alu_8bit.sv
// Registered ALU: eight ops, zero flag, one cycle of latency.
// Result and flag load together on every rising edge; sync active-low reset.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] dst,
  output logic             zflag
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] WMAX = WIDTH[WIDTH-1:0];

  op_e              op_sel;
  logic [7:0]       op_hot;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] shl_r;
  logic [WIDTH-1:0] shr_r;
  logic [WIDTH-1:0] slt_r;
  logic             sh_ovf;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] dst_d;
  logic [WIDTH-1:0] dst_q;
  logic             zflag_d;
  logic             zflag_q;

  assign op_sel = op_e'(op);

  always_comb begin
    op_hot = '0;
    op_hot[op_sel] = 1'b1;
  end

  // Shift amounts past the word width flush to zero.
  assign sh_ovf = (srcb >= WMAX);

  assign add_r = srca + srcb;
  assign sub_r = srca - srcb;
  assign and_r = srca & srcb;
  assign or_r  = srca | srcb;
  assign xor_r = srca ^ srcb;
  assign shl_r = sh_ovf ? '0 : (srca << srcb);
  assign shr_r = sh_ovf ? '0 : (srca >> srcb);
  assign slt_r = {{(WIDTH-1){1'b0}}, (srca < srcb)};

  always_comb begin
    res = '0;
    unique case (1'b1)
      op_hot[OP_ADD]: res = add_r;
      op_hot[OP_SUB]: res = sub_r;
      op_hot[OP_AND]: res = and_r;
      op_hot[OP_OR]:  res = or_r;
      op_hot[OP_XOR]: res = xor_r;
      op_hot[OP_SHL]: res = shl_r;
      op_hot[OP_SHR]: res = shr_r;
      op_hot[OP_SLT]: res = slt_r;
      default:        res = '0;
    endcase
  end

  always_comb begin
    dst_d   = res;
    zflag_d = (res == '0);
    if (!rst) begin
      dst_d   = '0;
      zflag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    dst_q   <= dst_d;
    zflag_q <= zflag_d;
  end

  assign dst   = dst_q;
  assign zflag = zflag_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: hand-computed vectors,
// one-cycle latency and hold-between-edges checks.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [2:0] op;
  logic [7:0] srca;
  logic [7:0] srcb;
  logic [7:0] dst;
  logic       zflag;

  int   n_run;
  int   n_fail;
  bit   have_prev;
  logic [7:0] prev_d;
  logic       prev_z;

  alu_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .dst   (dst),
    .zflag (zflag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input string tag, input logic r,
                      input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] ed,
                      input logic ez);
    rst  = r;
    op   = o;
    srca = a;
    srcb = b;
    #2;
    if (have_prev) begin
      n_run++;
      assert (dst === prev_d && zflag === prev_z) else begin
        n_fail++;
        $error("FAIL %s_hold: dst=%h z=%b required dst=%h z=%b",
               tag, dst, zflag, prev_d, prev_z);
      end
    end
    @(posedge clk);
    #1;
    n_run++;
    assert (dst === ed) else begin
      n_fail++;
      $error("FAIL %s_dst: got %h required %h", tag, dst, ed);
    end
    n_run++;
    assert (zflag === ez) else begin
      n_fail++;
      $error("FAIL %s_z: got %b required %b", tag, zflag, ez);
    end
    prev_d    = ed;
    prev_z    = ez;
    have_prev = 1'b1;
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    prev_d    = '0;
    prev_z    = 1'b0;
    rst  = 1'b0;
    op   = 3'b000;
    srca = 8'd3;
    srcb = 8'd2;

    for (int i = 0; i < 5; i++)
      step("reset", 1'b0, 3'b000, 8'd3, 8'd2, 8'h00, 1'b0);
    step("rst_rel_add", 1'b1, 3'b000, 8'd3, 8'd2, 8'h05, 1'b0);

    step("sub_4_5",   1'b1, 3'b001, 8'd4,  8'd5,  8'hFF, 1'b0);
    step("add_wrap",  1'b1, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
    step("sub_eq",    1'b1, 3'b001, 8'd3,  8'd3,  8'h00, 1'b1);
    step("add_big",   1'b1, 3'b000, 8'h80, 8'h7E, 8'hFE, 1'b0);

    step("and_1_2",   1'b1, 3'b010, 8'd1,  8'd2,  8'h00, 1'b1);
    step("or_3_3",    1'b1, 3'b011, 8'd3,  8'd3,  8'h03, 1'b0);
    step("xor_5_6",   1'b1, 3'b100, 8'd5,  8'd6,  8'h03, 1'b0);
    step("and_mask",  1'b1, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0);

    step("shl_1_3",   1'b1, 3'b101, 8'd1,  8'd3,  8'h08, 1'b0);
    step("shr_5_4",   1'b1, 3'b110, 8'd5,  8'd4,  8'h00, 1'b1);
    step("shl_81_1",  1'b1, 3'b101, 8'h81, 8'd1,  8'h02, 1'b0);
    step("shr_80_8",  1'b1, 3'b110, 8'h80, 8'd8,  8'h00, 1'b1);
    step("shr_80_7",  1'b1, 3'b110, 8'h80, 8'd7,  8'h01, 1'b0);
    step("shl_by0",   1'b1, 3'b101, 8'hA5, 8'd0,  8'hA5, 1'b0);
    step("shr_by0",   1'b1, 3'b110, 8'h5A, 8'd0,  8'h5A, 1'b0);
    step("shl_big",   1'b1, 3'b101, 8'hFF, 8'd200, 8'h00, 1'b1);

    step("slt_1_2",   1'b1, 3'b111, 8'd1,  8'd2,  8'h01, 1'b0);
    step("slt_2_1",   1'b1, 3'b111, 8'd2,  8'd1,  8'h00, 1'b1);
    step("slt_ff_01", 1'b1, 3'b111, 8'hFF, 8'h01, 8'h00, 1'b1);
    step("slt_eq",    1'b1, 3'b111, 8'd7,  8'd7,  8'h00, 1'b1);
    step("slt_01_ff", 1'b1, 3'b111, 8'h01, 8'hFF, 8'h01, 1'b0);

    step("mid_rst",   1'b0, 3'b010, 8'd6,  8'd2,  8'h00, 1'b0);
    step("post_rst",  1'b1, 3'b010, 8'd6,  8'd2,  8'h02, 1'b0);
    step("final_sub", 1'b1, 3'b001, 8'd0,  8'd1,  8'hFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- Registered 8-bit arithmetic/logic unit with an eight-entry opcode set and a zero flag.
- Sits in the datapath between the register file read ports (srca/srcb) and the write-back path.
- Result and flag are captured on the rising clock edge, giving one cycle of latency.

Parameters:
- WIDTH, 8, data width of srca, srcb and dst. All behaviour below is stated for WIDTH=8 and generalises bit-for-bit.

Ports:
- clk    input   1      system clock; all state updates on the rising edge
- rst    input   1      reset; synchronous, active-low (0 = reset)
- op     input   3      operation select
- srca   input   WIDTH  operand A
- srcb   input   WIDTH  operand B
- dst    output  WIDTH  registered result
- zflag  output  1      registered zero flag; 1 when the registered dst equals 0 after a non-reset cycle

Behaviour:
- One clock, no other state. All inputs are sampled at the rising edge of clk.
- Reset: if rst==0 at a rising edge, then dst<=0 and zflag<=0. Reset takes priority over any op.
- A reset asserted mid-sequence discards that cycle's operation. Inputs held during reset have no effect afterwards.
- Normal cycle (rst==1): dst<=f(op,srca,srcb) and zflag<=(f(op,srca,srcb)==0).
  - Both update in the same edge; no stall or enable.
  - Result visible one cycle after inputs are presented.
  - Outputs hold between edges; a new value loads every edge.
- Opcode map (all results truncated to WIDTH bits, operands unsigned):
  - 000 ADD: srca+srcb, modulo 2^WIDTH; carry discarded.
  - 001 SUB: srca-srcb, two's complement wrap. Example: 4-5 = 8'hFF.
  - 010 AND: srca & srcb.
  - 011 OR: srca | srcb.
  - 100 XOR: srca ^ srcb.
  - 101 SHL: srca shifted left logically by srcb; zero fill. If srcb >= WIDTH, result is 0.
  - 110 SHR: srca shifted right logically by srcb; zero fill. If srcb >= WIDTH, result is 0.
  - 111 SLT: unsigned set-less-than. Result is 1 if srca<srcb, else 0; upper bits are 0.
- zflag is derived from the same combinational result that is loaded into dst, so it is always consistent with dst except in the reset state.
- Combinational datapath is a single-cycle mux of the eight function units. No multicycle paths.
- There are no X or illegal opcodes; all eight encodings are defined.
- Wrap-around and boundary cases:
  - ADD 8'hFF+8'h01 = 8'h00, zflag=1.
  - SUB x-x = 0, zflag=1.
  - SHL/SHR by 0 returns srca unchanged.
  - SLT with equal operands returns 0, zflag=1.
- Changing op or operands between edges has no effect on the outputs until the next edge.

Test Plan:
- Reset: rst=0, op=000, srca=3, srcb=2, clocked for 5 cycles -> dst=0 and zflag=0 every cycle. Then rst=1 with the same inputs -> next edge dst=5, zflag=0.
- Arithmetic (rst=1):
  - SUB 4-5 -> dst=8'hFF, zflag=0.
  - ADD 8'hFF+8'h01 -> dst=0, zflag=1.
  - SUB 3-3 -> dst=0, zflag=1.
- Logic (rst=1):
  - AND 1&2 -> dst=0, zflag=1.
  - OR 3|3 -> dst=3, zflag=0.
  - XOR 5^6 -> dst=3, zflag=0.
- Shifts (rst=1):
  - SHL 1 by 3 -> dst=8.
  - SHR 5 by 4 -> dst=0, zflag=1.
  - SHL 8'h81 by 1 -> dst=8'h02.
  - SHR 8'h80 by 8 -> dst=0.
  - SHL by 0 -> srca unchanged.
- Compare (rst=1):
  - SLT 1<2 -> dst=1, zflag=0.
  - SLT 2<1 -> dst=0, zflag=1.
  - SLT 8'hFF vs 8'h01 -> dst=0 (unsigned).
- Reset mid-operation: after SLT produces dst=1, drive rst=0 with op=010, srca=6, srcb=2 -> next edge dst=0, zflag=0. Release rst=1 -> next edge dst=2 (6&2), zflag=0. Also check that results change only on rising edges, with exactly one-cycle latency.
